// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, count type and horizontal phase enumeration
// for the vga_timing block.
package vga_timing_pkg;

   localparam int unsigned CNT_W = 10;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FRONT  = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BACK   = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FRONT  = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BACK   = 33;

   localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      FRONT  = 2'd1,
      SYNC   = 2'd2,
      BACK   = 2'd3
   } hstate_e;

   function automatic cnt_t wrap_inc(input cnt_t value, input cnt_t last);
      return (value == last) ? '0 : cnt_t'(value + cnt_t'(1));
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Generic wrap counter for one display axis, exposing the next count together with
// its active-region and sync-window decode so the parent can register them skew-free.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned TOTAL      = DEF_H_TOTAL,
   parameter int unsigned ACTIVE_LEN = DEF_H_ACTIVE,
   parameter int unsigned SYNC_START = DEF_H_ACTIVE + DEF_H_FRONT,
   parameter int unsigned SYNC_LEN   = DEF_H_SYNC
) (
   input  logic clock,
   input  logic reset,
   input  logic step_i,
   output cnt_t count_o,
   output cnt_t count_d_o,
   output logic wrap_o,
   output logic active_d_o,
   output logic sync_d_o
);

   localparam cnt_t LAST    = cnt_t'(TOTAL - 1);
   localparam cnt_t ACT_END = cnt_t'(ACTIVE_LEN);
   localparam cnt_t SYNC_LO = cnt_t'(SYNC_START);
   localparam cnt_t SYNC_HI = cnt_t'(SYNC_START + SYNC_LEN);

   cnt_t count_q;
   cnt_t count_d;

   always_comb begin
      // NOTE: default assignment first so every path drives count_d and no latch is inferred.
      count_d = count_q;
      if (step_i) begin
         count_d = wrap_inc(count_q, LAST);
      end
   end

   // Reset parks on the last position so the first step lands on 0.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: non-blocking assignment for state so all flops update from pre-edge values.
      if (reset) begin
         count_q <= LAST;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o    = count_q;
   assign count_d_o  = count_d;
   assign wrap_o     = step_i && (count_q == LAST);
   assign active_d_o = (count_d < ACT_END);
   assign sync_d_o   = (count_d >= SYNC_LO) && (count_d < SYNC_HI);

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel-rate strobe, h/v counters, registered sync/enable.
// Optional VGA_TIMING_FRAME_COUNT_EN adds an 8-bit wrapping frame counter output.
module vga_timing
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FRONT  = DEF_H_FRONT,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BACK   = DEF_H_BACK,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FRONT  = DEF_V_FRONT,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BACK   = DEF_V_BACK
) (
   input  logic             clock,
   input  logic             reset,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             enable,
   output logic             hsync,
   output logic             vsync,
   output logic             pixel_tick,
   output logic             frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
   ,
   output logic [7:0]       frame_count
`endif
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam cnt_t H_FRONT_AT = cnt_t'(H_ACTIVE);
   localparam cnt_t H_SYNC_AT  = cnt_t'(H_ACTIVE + H_FRONT);
   localparam cnt_t H_BACK_AT  = cnt_t'(H_ACTIVE + H_FRONT + H_SYNC);

   logic    tick_q;
   cnt_t    h_count;
   cnt_t    h_count_d;
   cnt_t    v_count;
   cnt_t    v_count_d;
   logic    h_wrap;
   logic    v_wrap_unused;
   logic    h_active_d;
   logic    v_active_d;
   logic    h_win_unused;
   logic    v_in_sync_d;
   hstate_e state_q;
   hstate_e state_d;
   logic    enable_q;
   logic    enable_d;
   logic    hsync_q;
   logic    hsync_d;
   logic    vsync_q;
   logic    vsync_d;
   logic    frame_start_q;
   logic    frame_start_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tick_q <= 1'b0;
      end else begin
         tick_q <= ~tick_q;
      end
   end

   vga_axis_counter #(
      .TOTAL      (H_TOTAL),
      .ACTIVE_LEN (H_ACTIVE),
      .SYNC_START (H_ACTIVE + H_FRONT),
      .SYNC_LEN   (H_SYNC)
   ) u_h_axis (
      .clock      (clock),
      .reset      (reset),
      .step_i     (tick_q),
      .count_o    (h_count),
      .count_d_o  (h_count_d),
      .wrap_o     (h_wrap),
      .active_d_o (h_active_d),
      .sync_d_o   (h_win_unused)
   );

   vga_axis_counter #(
      .TOTAL      (V_TOTAL),
      .ACTIVE_LEN (V_ACTIVE),
      .SYNC_START (V_ACTIVE + V_FRONT),
      .SYNC_LEN   (V_SYNC)
   ) u_v_axis (
      .clock      (clock),
      .reset      (reset),
      .step_i     (h_wrap),
      .count_o    (v_count),
      .count_d_o  (v_count_d),
      .wrap_o     (v_wrap_unused),
      .active_d_o (v_active_d),
      .sync_d_o   (v_in_sync_d)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= BACK;
      end else begin
         state_q <= state_d;
      end
   end

   // Phase changes on the same edge hcount lands on a boundary value.
   always_comb begin
      state_d = state_q;
      if (tick_q) begin
         if (h_count_d == '0) begin
            state_d = ACTIVE;
         end else if (h_count_d == H_FRONT_AT) begin
            state_d = FRONT;
         end else if (h_count_d == H_SYNC_AT) begin
            state_d = SYNC;
         end else if (h_count_d == H_BACK_AT) begin
            state_d = BACK;
         end
      end
   end

   // Decoded from next-state/next-count so the registered outputs move with the counters.
   always_comb begin
      hsync_d       = (state_d != SYNC);
      vsync_d       = ~v_in_sync_d;
      enable_d      = h_active_d && v_active_d;
      frame_start_d = tick_q && (h_count_d == '0) && (v_count_d == '0);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         enable_q      <= 1'b0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         enable_q      <= enable_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         frame_start_q <= frame_start_d;
      end
   end

`ifdef VGA_TIMING_FRAME_COUNT_EN
   logic [7:0] frame_count_q;
   logic [7:0] frame_count_d;

   assign frame_count_d = frame_count_q + {7'd0, frame_start_q};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         frame_count_q <= 8'd0;
      end else begin
         frame_count_q <= frame_count_d;
      end
   end

   assign frame_count = frame_count_q;
`endif

   assign hcount      = h_count;
   assign vcount      = v_count;
   assign enable      = enable_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign pixel_tick  = tick_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: a full 640x480 instance plus a tiny-raster instance,
// both compared against an arithmetic model driven by clocks elapsed since reset release.
module tb_vga_timing;

   typedef struct {
      int ha, hf, hs, hb, va, vf, vs, vb;
   } cfg_t;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       en;
      logic       hs;
      logic       vs;
      logic       tick;
      logic       fs;
   } obs_t;

   cfg_t full_cfg  = '{640, 16, 96, 48, 480, 10, 2, 33};
   cfg_t small_cfg = '{4, 1, 2, 1, 3, 1, 2, 1};

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   int         k;
   int         checks = 0;
   int         errors = 0;

   logic [9:0] hcount_f, vcount_f, hcount_s, vcount_s;
   logic       en_f, hs_f, vs_f, tick_f, fs_f;
   logic       en_s, hs_s, vs_s, tick_s, fs_s;
`ifdef VGA_TIMING_FRAME_COUNT_EN
   logic [7:0] fc_f, fc_s;
`endif

   obs_t obs_f, obs_s;
   assign obs_f = {hcount_f, vcount_f, en_f, hs_f, vs_f, tick_f, fs_f};
   assign obs_s = {hcount_s, vcount_s, en_s, hs_s, vs_s, tick_s, fs_s};

   vga_timing dut_full (
      .clock       (clock),
      .reset       (reset),
      .hcount      (hcount_f),
      .vcount      (vcount_f),
      .enable      (en_f),
      .hsync       (hs_f),
      .vsync       (vs_f),
      .pixel_tick  (tick_f),
      .frame_start (fs_f)
`ifdef VGA_TIMING_FRAME_COUNT_EN
      ,
      .frame_count (fc_f)
`endif
   );

   vga_timing #(
      .H_ACTIVE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
      .V_ACTIVE (3), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
   ) dut_small (
      .clock       (clock),
      .reset       (reset),
      .hcount      (hcount_s),
      .vcount      (vcount_s),
      .enable      (en_s),
      .hsync       (hs_s),
      .vsync       (vs_s),
      .pixel_tick  (tick_s),
      .frame_start (fs_s)
`ifdef VGA_TIMING_FRAME_COUNT_EN
      ,
      .frame_count (fc_s)
`endif
   );

   always #10 clock = ~clock;

   // Clock edges seen since the last reset release.
   always @(posedge clock or posedge reset) begin
      if (reset) k <= 0;
      else       k <= k + 1;
   end

   // Position is (ticks-1) along a linear raster scan; ticks happen on even edges.
   function automatic obs_t model(input int kk, input cfg_t c);
      obs_t e;
      int ht, vt, n, p, h, v;
      ht = c.ha + c.hf + c.hs + c.hb;
      vt = c.va + c.vf + c.vs + c.vb;
      n  = kk / 2;
      p  = -1;
      if (n == 0) begin
         h = ht - 1;
         v = vt - 1;
      end else begin
         p = (n - 1) % (ht * vt);
         h = p % ht;
         v = p / ht;
      end
      e.h    = 10'(h);
      e.v    = 10'(v);
      e.en   = (h < c.ha) && (v < c.va);
      e.hs   = !((h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs));
      e.vs   = !((v >= c.va + c.vf) && (v < c.va + c.vf + c.vs));
      e.tick = (kk % 2) == 1;
      e.fs   = (n > 0) && ((kk % 2) == 0) && (p == 0);
      return e;
   endfunction

   function automatic int model_fc(input int kk, input cfg_t c);
      int frame_clks;
      frame_clks = 2 * (c.ha + c.hf + c.hs + c.hb) * (c.va + c.vf + c.vs + c.vb);
      if (kk <= 2) return 0;
      return (((kk - 3) / frame_clks) + 1) % 256;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checks += 2;
         if (obs_f !== model(0, full_cfg)) begin
            errors++;
            $display("FAIL reset_full got=%h exp=%h", obs_f, model(0, full_cfg));
         end
         if (obs_s !== model(0, small_cfg)) begin
            errors++;
            $display("FAIL reset_small got=%h exp=%h", obs_s, model(0, small_cfg));
         end
      end
`ifdef VGA_TIMING_FRAME_COUNT_EN
      checks++;
      if (fc_s !== 8'd0) begin
         errors++;
         $display("FAIL reset_frame_count got=%0d exp=0", fc_s);
      end
`endif
   endtask

   task automatic test_startup();
      logic [3:0] pat;
      pat = 4'b1010;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clock);
         checks += 2;
         if (obs_f !== model(k, full_cfg)) begin
            errors++;
            $display("FAIL startup_full k=%0d got=%h exp=%h", k, obs_f, model(k, full_cfg));
         end
         if (obs_s !== model(k, small_cfg)) begin
            errors++;
            $display("FAIL startup_small k=%0d got=%h exp=%h", k, obs_s, model(k, small_cfg));
         end
         if (i < 4) begin
            checks++;
            if (tick_f !== pat[i]) begin
               errors++;
               $display("FAIL startup_tick cycle=%0d got=%b exp=%b", i, tick_f, pat[i]);
            end
         end
         if (i == 2) begin
            checks++;
            if ({hcount_f, vcount_f, en_f, fs_f} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
               errors++;
               $display("FAIL startup_first_tick got h=%0d v=%0d en=%b fs=%b exp h=0 v=0 en=1 fs=1",
                        hcount_f, vcount_f, en_f, fs_f);
            end
         end
         if (i == 3) begin
            checks++;
            if (fs_f !== 1'b0) begin
               errors++;
               $display("FAIL startup_fs_width got=%b exp=0", fs_f);
            end
         end
      end
   endtask

   task automatic test_hsync();
      int         fall_k[$];
      logic       prev_hs;
      logic [9:0] prev_h;
      prev_hs = hs_f;
      prev_h  = hcount_f;
      for (int i = 0; i < 3400 && fall_k.size() < 2; i++) begin
         @(negedge clock);
         checks++;
         if (obs_f !== model(k, full_cfg)) begin
            errors++;
            $display("FAIL hsync_run_full k=%0d got=%h exp=%h", k, obs_f, model(k, full_cfg));
         end
         if (prev_hs && !hs_f) begin
            fall_k.push_back(k);
            checks++;
            if (prev_h !== 10'd655 || hcount_f !== 10'd656) begin
               errors++;
               $display("FAIL hsync_fall got=%0d->%0d exp=655->656", prev_h, hcount_f);
            end
         end
         if (!prev_hs && hs_f) begin
            checks++;
            if (prev_h !== 10'd751 || hcount_f !== 10'd752) begin
               errors++;
               $display("FAIL hsync_rise got=%0d->%0d exp=751->752", prev_h, hcount_f);
            end
         end
         prev_hs = hs_f;
         prev_h  = hcount_f;
      end
      checks++;
      if (fall_k.size() != 2) begin
         errors++;
         $display("FAIL hsync_timeout got=%0d falls exp=2", fall_k.size());
      end else if (fall_k[1] - fall_k[0] != 1600) begin
         errors++;
         $display("FAIL line_length got=%0d exp=1600", fall_k[1] - fall_k[0]);
      end
   endtask

   task automatic test_vertical();
      logic [6:0] vlow;
      logic       seen_last_active;
      logic       checked_after;
      vlow = '0;
      seen_last_active = 1'b0;
      checked_after    = 1'b0;
      for (int i = 0; i < 224; i++) begin
         @(negedge clock);
         checks++;
         if (obs_s !== model(k, small_cfg)) begin
            errors++;
            $display("FAIL vert_run_small k=%0d got=%h exp=%h", k, obs_s, model(k, small_cfg));
         end
         if (!vs_s && vcount_s < 10'd7) vlow[vcount_s[2:0]] = 1'b1;
         if (hcount_s == 10'd3 && vcount_s == 10'd2 && !seen_last_active) begin
            seen_last_active = 1'b1;
            checks++;
            if (en_s !== 1'b1) begin
               errors++;
               $display("FAIL enable_last_pixel got=%b exp=1", en_s);
            end
         end else if (seen_last_active && !checked_after && hcount_s == 10'd4) begin
            checked_after = 1'b1;
            checks++;
            if (en_s !== 1'b0) begin
               errors++;
               $display("FAIL enable_after_last got=%b exp=0", en_s);
            end
         end
      end
      checks++;
      if (vlow !== 7'b0110000 || !checked_after) begin
         errors++;
         $display("FAIL vsync_window got=%b exp=0110000 seen=%b", vlow, checked_after);
      end
   endtask

   task automatic test_frame();
      int         pulse_k[$];
      logic [9:0] prev_h, prev_v;
      prev_h = hcount_s;
      prev_v = vcount_s;
      for (int i = 0; i < 3 * 112; i++) begin
         @(negedge clock);
         checks++;
         if (obs_s !== model(k, small_cfg)) begin
            errors++;
            $display("FAIL frame_run_small k=%0d got=%h exp=%h", k, obs_s, model(k, small_cfg));
         end
         if (fs_s) begin
            pulse_k.push_back(k);
            checks++;
            if ({prev_h, prev_v, hcount_s, vcount_s} !== {10'd7, 10'd6, 10'd0, 10'd0}) begin
               errors++;
               $display("FAIL frame_wrap got=(%0d,%0d)->(%0d,%0d) exp=(7,6)->(0,0)",
                        prev_h, prev_v, hcount_s, vcount_s);
            end
         end
         prev_h = hcount_s;
         prev_v = vcount_s;
      end
      checks++;
      if (pulse_k.size() != 3) begin
         errors++;
         $display("FAIL frame_pulses got=%0d exp=3", pulse_k.size());
      end else if (pulse_k[1] - pulse_k[0] != 112 || pulse_k[2] - pulse_k[1] != 112) begin
         errors++;
         $display("FAIL frame_period got=%0d,%0d exp=112", pulse_k[1] - pulse_k[0],
                  pulse_k[2] - pulse_k[1]);
      end
`ifdef VGA_TIMING_FRAME_COUNT_EN
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 257 * 112 + 4; i++) begin
         @(negedge clock);
         checks++;
         if (int'(fc_s) != model_fc(k, small_cfg)) begin
            errors++;
            $display("FAIL frame_count k=%0d got=%0d exp=%0d", k, fc_s, model_fc(k, small_cfg));
         end
      end
`endif
   endtask

   task automatic test_mid_reset();
      int run_len;
      for (int iter = 0; iter < 4; iter++) begin
         run_len = int'($urandom_range(40, 2500));
         for (int i = 0; i < run_len; i++) begin
            @(negedge clock);
            checks += 2;
            if (obs_f !== model(k, full_cfg)) begin
               errors++;
               $display("FAIL rand_run_full k=%0d got=%h exp=%h", k, obs_f, model(k, full_cfg));
            end
            if (obs_s !== model(k, small_cfg)) begin
               errors++;
               $display("FAIL rand_run_small k=%0d got=%h exp=%h", k, obs_s, model(k, small_cfg));
            end
         end
         #3 reset = 1'b1;
         #1;
         checks += 2;
         if (obs_f !== model(0, full_cfg)) begin
            errors++;
            $display("FAIL async_reset_full got=%h exp=%h", obs_f, model(0, full_cfg));
         end
         if (obs_s !== model(0, small_cfg)) begin
            errors++;
            $display("FAIL async_reset_small got=%h exp=%h", obs_s, model(0, small_cfg));
         end
         for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (obs_f !== model(0, full_cfg)) begin
               errors++;
               $display("FAIL reset_hold_full got=%h exp=%h", obs_f, model(0, full_cfg));
            end
         end
         reset = 1'b0;
         for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            checks += 2;
            if (obs_f !== model(k, full_cfg)) begin
               errors++;
               $display("FAIL resume_full k=%0d got=%h exp=%h", k, obs_f, model(k, full_cfg));
            end
            if (obs_s !== model(k, small_cfg)) begin
               errors++;
               $display("FAIL resume_small k=%0d got=%h exp=%h", k, obs_s, model(k, small_cfg));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_hsync();
      test_vertical();
      test_frame();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
